// File: rtl/score_bcd_counter.sv
// Catch-The-LED score keeper: hit/miss rising edges become +1/-1 on a packed BCD score.
// Optional high-score register enabled by defining HIGH_SCORE_EN.
module score_bcd_counter #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                enable,
   input  logic                hit,
   input  logic                miss,
   output logic [4*DIGITS-1:0] score_digits,
   output logic                score_max,
   output logic                changed,
   output logic [4*DIGITS-1:0] hi_digits
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

   logic         hit_q, miss_q;
   logic [W-1:0] score_q, score_d;
   logic [W-1:0] score_inc, score_dec;
   logic         score_max_q, changed_q, changed_d;
   logic         inc, dec, at_max, at_zero;

   assign inc     = hit & ~hit_q;
   assign dec     = miss & ~miss_q;
   assign at_max  = (score_q == ALL_NINES);
   assign at_zero = (score_q == '0);

   // Per-digit BCD ripple: a 9 wraps to 0 and carries into the next digit.
   always_comb begin : bcd_inc
      logic carry;
      carry     = 1'b1;
      score_inc = score_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_comb begin : bcd_dec
      logic borrow;
      borrow    = 1'b1;
      score_dec = score_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (score_q[4*i +: 4] == 4'd0) begin
               score_dec[4*i +: 4] = 4'd9;
            end else begin
               score_dec[4*i +: 4] = score_q[4*i +: 4] - 4'd1;
               borrow              = 1'b0;
            end
         end
      end
   end

   always_comb begin : next_score
      score_d   = score_q;
      changed_d = 1'b0;
      if (clear) begin
         score_d   = '0;
         changed_d = ~at_zero;
      end else if (enable) begin
         if (inc && !dec && !at_max) begin
            score_d   = score_inc;
            changed_d = 1'b1;
         end else if (dec && !inc && !at_zero) begin
            score_d   = score_dec;
            changed_d = 1'b1;
         end
      end
   end

   // Edge-detect history resets high so a button held through reset never scores.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_q       <= 1'b1;
         miss_q      <= 1'b1;
         score_q     <= '0;
         score_max_q <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         hit_q       <= hit;
         miss_q      <= miss;
         score_q     <= score_d;
         score_max_q <= (score_d == ALL_NINES);
         changed_q   <= changed_d;
      end
   end

   assign score_digits = score_q;
   assign score_max    = score_max_q;
   assign changed      = changed_q;

`ifdef HIGH_SCORE_EN
   logic [W-1:0] hi_q;

   // Valid BCD orders the same as unsigned binary, so a plain compare is numeric.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
      end else if (score_q > hi_q) begin
         hi_q <= score_q;
      end
   end

   assign hi_digits = hi_q;
`else
   assign hi_digits = '0;
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed + random bench for score_bcd_counter; an integer reference model feeds an
// expected-result queue that is drained one entry per clock.
module tb_score_bcd_counter;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 99;
   localparam int EW     = 2 * W + 2;

   logic         clk;
   logic         rst_n;
   logic         clear;
   logic         enable;
   logic         hit;
   logic         miss;
   logic [W-1:0] score_digits;
   logic         score_max;
   logic         changed;
   logic [W-1:0] hi_digits;

   int tests_run = 0;
   int fail_cnt  = 0;

   logic [EW-1:0] exp_q[$];

   // reference model state
   int   score_m = 0;
   int   hi_m    = 0;
   logic ph      = 1'b1;
   logic pm      = 1'b1;

   score_bcd_counter #(.DIGITS(DIGITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .enable      (enable),
      .hit         (hit),
      .miss        (miss),
      .score_digits(score_digits),
      .score_max   (score_max),
      .changed     (changed),
      .hi_digits   (hi_digits)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // scoreboard: pop one expected entry and compare every output
   task automatic compare_outputs();
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         tests_run++;
         fail_cnt++;
         $error("FAIL scoreboard_empty observed=0 expected=1 entries");
      end else begin
         e = exp_q.pop_front();
         check("score", score_digits, e[W-1:0]);
         check("score_max", W'(score_max), W'(e[W]));
         check("changed", W'(changed), W'(e[W+1]));
         check("hi_digits", hi_digits, e[EW-1:W+2]);
      end
   endtask

   // driver: one clock with the given inputs, model predicts, scoreboard checks
   task automatic step(input logic h, input logic m, input logic c, input logic en);
      logic inc, dec, chg;
      @(negedge clk);
      rst_n  = 1'b1;
      hit    = h;
      miss   = m;
      clear  = c;
      enable = en;
      inc = h & ~ph;
      dec = m & ~pm;
      ph  = h;
      pm  = m;
`ifdef HIGH_SCORE_EN
      if (score_m > hi_m) hi_m = score_m;
`endif
      chg = 1'b0;
      if (c) begin
         chg     = (score_m != 0);
         score_m = 0;
      end else if (en) begin
         if (inc && !dec && score_m < MAXV) begin
            score_m++;
            chg = 1'b1;
         end else if (dec && !inc && score_m > 0) begin
            score_m--;
            chg = 1'b1;
         end
      end
      exp_q.push_back({to_bcd(hi_m), chg, (score_m == MAXV), to_bcd(score_m)});
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic do_reset(input logic h, input logic m);
      @(negedge clk);
      rst_n  = 1'b0;
      hit    = h;
      miss   = m;
      clear  = 1'b0;
      enable = 1'b1;
      ph      = 1'b1;
      pm      = 1'b1;
      score_m = 0;
      hi_m    = 0;
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic hit_pulses(input int n);
      repeat (n) begin
         step(1'b1, 1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic miss_pulses(input int n);
      repeat (n) begin
         step(1'b0, 1'b1, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      clear  = 1'b0;
      enable = 1'b1;
      hit    = 1'b1;
      miss   = 1'b0;

      // reset with hit held: no score until hit falls and rises again
      do_reset(1'b1, 1'b0);
      do_reset(1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("held_through_reset", score_digits, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("first_hit", score_digits, 8'h01);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // high score: 37, clear, 05 -> hi 37; then 38 -> hi 38 a cycle later
      hit_pulses(36);
      check("score_37", score_digits, 8'h37);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      hit_pulses(5);
      check("score_05", score_digits, 8'h05);
`ifdef HIGH_SCORE_EN
      check("hi_after_clear", hi_digits, 8'h37);
`else
      check("hi_tied_zero", hi_digits, 8'h00);
`endif
      hit_pulses(33);
      check("score_38", score_digits, 8'h38);

      // 100 pulses from zero: carry through 09->10, saturate at 99
      step(1'b0, 1'b0, 1'b1, 1'b1);
      hit_pulses(9);
      check("score_09", score_digits, 8'h09);
      hit_pulses(1);
      check("carry_10", score_digits, 8'h10);
      hit_pulses(89);
      check("score_99", score_digits, 8'h99);
      check("max_at_99", W'(score_max), 8'h01);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("sat_changed", W'(changed), 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // borrow 10 -> 09, floor at 00
      step(1'b0, 1'b0, 1'b1, 1'b1);
      hit_pulses(10);
      miss_pulses(1);
      check("borrow_09", score_digits, 8'h09);
      miss_pulses(9);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("floor_changed", W'(changed), 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // simultaneous hit+miss at 42 cancels; clear wins over hit
      hit_pulses(42);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("cancel_42", score_digits, 8'h42);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("clear_over_hit", score_digits, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // disabled: edges discarded; enabling while hit held does not count
      hit_pulses(3);
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("enable_while_held", score_digits, 8'h03);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // random traffic
      repeat (400) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 5) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
